// File: rtl/debug_unit_v2.sv
// UART debug controller for the MIPS core: program load, run/step with a PC
// breakpoint, manual break, core reset and an XOR-checksummed state dump.
module debug_unit_v2 #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned NREGS      = 32,
   parameter int unsigned NMEM       = 16,
   parameter int unsigned IMEM_DEPTH = 256,
   localparam int unsigned NBITS     = 8 * WORD_BYTES,
   localparam int unsigned REG_AW    = $clog2(NREGS),
   localparam int unsigned MEM_AW    = $clog2(NMEM),
   localparam int unsigned IMEM_AW   = $clog2(IMEM_DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_tx_busy,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_halt,
   input  logic [NBITS-1:0]   i_pc,
   input  logic [NBITS-1:0]   i_cycle_count,
   input  logic [NBITS-1:0]   i_reg_data,
   input  logic [NBITS-1:0]   i_mem_data,
   output logic [REG_AW-1:0]  o_reg_addr,
   output logic [MEM_AW-1:0]  o_mem_addr,
   output logic [IMEM_AW-1:0] o_imem_addr,
   output logic [NBITS-1:0]   o_imem_data,
   output logic               o_imem_we,
   output logic               o_cpu_en,
   output logic               o_cpu_reset,
   output logic               o_error,
   output logic [3:0]         o_state
);

   localparam int unsigned NWORDS = 2 + NREGS + NMEM;
   localparam int unsigned WIDX_W = $clog2(NWORDS);
   localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);

   localparam logic [7:0] CMD_LOAD  = 8'h6C;
   localparam logic [7:0] CMD_RUN   = 8'h63;
   localparam logic [7:0] CMD_STEP  = 8'h73;
   localparam logic [7:0] CMD_BRK   = 8'h62;
   localparam logic [7:0] CMD_DUMP  = 8'h64;
   localparam logic [7:0] CMD_RST   = 8'h72;
   localparam logic [7:0] CMD_KILL  = 8'h6B;
   localparam logic [7:0] CMD_BREAK = 8'h78;
   localparam logic [7:0] CMD_NEXT  = 8'h6E;
   localparam logic [7:0] CMD_QUIT  = 8'h71;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD   = 4'd1,
      S_BRK    = 4'd2,
      S_RUN    = 4'd3,
      S_STEP   = 4'd4,
      S_D_ADDR = 4'd5,
      S_D_LOAD = 4'd6,
      S_D_SEND = 4'd7,
      S_D_WAIT = 4'd8,
      S_D_CSUM = 4'd9
   } state_t;

   state_t             state_q, state_d;
   state_t             ret_q, ret_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NBITS-1:0]   word_q, word_d;
   logic [IMEM_AW-1:0] addr_q, addr_d;
   logic [NBITS-1:0]   bp_q, bp_d;
   logic               bp_en_q, bp_en_d;
   logic               first_q, first_d;
   logic [WIDX_W-1:0]  widx_q, widx_d;
   logic [NBITS-1:0]   shift_q, shift_d;
   logic [7:0]         csum_q, csum_d;
   logic [7:0]         tx_q, tx_d;
   logic               start_q, start_d;
   logic               hold_q, hold_d;
   logic               csum_sent_q, csum_sent_d;
   logic               we_q, we_d;
   logic               err_q, err_d;
   logic               crst_q, crst_d;
   logic               cpu_en;

   logic [IMEM_AW:0]   addr_nx;
   logic [NBITS-1:0]   word_sel;
   logic [7:0]         tx_byte;
   logic               stop;
   logic               in_regs;
   logic               in_mem;

   assign addr_nx = {1'b0, addr_q} + (IMEM_AW+1)'(WORD_BYTES);
   assign tx_byte = shift_q[NBITS-1 -: 8];
   assign in_regs = (widx_q >= WIDX_W'(2)) && (widx_q < WIDX_W'(2 + NREGS));
   assign in_mem  = (widx_q >= WIDX_W'(2 + NREGS));
   // The breakpoint is masked on the first RUN cycle so a resume from it can leave.
   assign stop = i_halt
              || (bp_en_q && (i_pc == bp_q) && !first_q)
              || (i_rx_valid && (i_rx_data == CMD_BREAK));

   always_comb begin
      if (widx_q == '0) begin
         word_sel = i_pc;
      end else if (widx_q == WIDX_W'(1)) begin
         word_sel = i_cycle_count;
      end else if (in_regs) begin
         word_sel = i_reg_data;
      end else begin
         word_sel = i_mem_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      addr_d      = addr_q;
      bp_d        = bp_q;
      bp_en_d     = bp_en_q;
      first_d     = first_q;
      widx_d      = widx_q;
      shift_d     = shift_q;
      csum_d      = csum_q;
      tx_d        = tx_q;
      start_d     = 1'b0;
      hold_d      = hold_q;
      csum_sent_d = csum_sent_q;
      we_d        = 1'b0;
      err_d       = 1'b0;
      crst_d      = 1'b0;
      cpu_en      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               unique case (i_rx_data)
                  CMD_LOAD: begin
                     state_d = S_LOAD;
                     cnt_d   = '0;
                  end
                  CMD_RUN: begin
                     state_d = S_RUN;
                     first_d = 1'b1;
                  end
                  CMD_STEP: state_d = S_STEP;
                  CMD_BRK: begin
                     state_d = S_BRK;
                     cnt_d   = '0;
                  end
                  CMD_DUMP: begin
                     state_d = S_D_ADDR;
                     ret_d   = S_IDLE;
                     widx_d  = '0;
                     csum_d  = '0;
                  end
                  CMD_RST:  crst_d  = 1'b1;
                  CMD_KILL: bp_en_d = 1'b0;
                  default:  err_d   = 1'b1;
               endcase
            end
         end

         S_LOAD: begin
            // we_q marks the write cycle; rx bytes landing in it are dropped.
            if (we_q) begin
               if (word_q == '1) begin
                  addr_d  = '0;
                  state_d = S_IDLE;
               end else if (addr_nx > (IMEM_AW+1)'(IMEM_DEPTH - WORD_BYTES)) begin
                  addr_d = '0;
                  err_d  = 1'b1;
               end else begin
                  addr_d = addr_nx[IMEM_AW-1:0];
               end
            end else if (i_rx_valid) begin
               word_d = (word_q << 8) | NBITS'(i_rx_data);
               if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                  cnt_d = '0;
                  we_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_BRK: begin
            if (i_rx_valid) begin
               bp_d = (bp_q << 8) | NBITS'(i_rx_data);
               if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                  cnt_d   = '0;
                  bp_en_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_RUN: begin
            first_d = 1'b0;
            if (stop) begin
               state_d = S_D_ADDR;
               ret_d   = S_IDLE;
               widx_d  = '0;
               csum_d  = '0;
            end else begin
               cpu_en = 1'b1;
            end
         end

         S_STEP: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_NEXT) begin
                  state_d = S_D_ADDR;
                  widx_d  = '0;
                  csum_d  = '0;
                  if (i_halt) begin
                     ret_d = S_IDLE;
                  end else begin
                     ret_d  = S_STEP;
                     cpu_en = 1'b1;
                  end
               end else if (i_rx_data == CMD_QUIT) begin
                  state_d = S_IDLE;
               end
            end
         end

         S_D_ADDR: state_d = S_D_LOAD;

         S_D_LOAD: begin
            shift_d = word_sel;
            cnt_d   = '0;
            state_d = S_D_SEND;
         end

         S_D_SEND: begin
            if (!i_tx_busy) begin
               tx_d    = tx_byte;
               shift_d = shift_q << 8;
               csum_d  = csum_q ^ tx_byte;
               cnt_d   = cnt_q + CNT_W'(1);
               start_d = 1'b1;
               hold_d  = 1'b1;
               state_d = S_D_WAIT;
            end
         end

         // First cycle here is the start pulse, second is the busy-ignore cycle.
         S_D_WAIT: begin
            if (hold_q) begin
               hold_d = 1'b0;
            end else if (csum_sent_q) begin
               csum_sent_d = 1'b0;
               widx_d      = '0;
               state_d     = ret_q;
            end else if (cnt_q == CNT_W'(WORD_BYTES)) begin
               if (widx_q == WIDX_W'(NWORDS - 1)) begin
                  state_d = S_D_CSUM;
               end else begin
                  widx_d  = widx_q + WIDX_W'(1);
                  state_d = S_D_ADDR;
               end
            end else begin
               state_d = S_D_SEND;
            end
         end

         S_D_CSUM: begin
            if (!i_tx_busy) begin
               tx_d        = csum_q;
               start_d     = 1'b1;
               hold_d      = 1'b1;
               csum_sent_d = 1'b1;
               state_d     = S_D_WAIT;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         ret_q       <= S_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         bp_q        <= '0;
         bp_en_q     <= 1'b0;
         first_q     <= 1'b0;
         widx_q      <= '0;
         shift_q     <= '0;
         csum_q      <= '0;
         tx_q        <= '0;
         start_q     <= 1'b0;
         hold_q      <= 1'b0;
         csum_sent_q <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         crst_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         bp_q        <= bp_d;
         bp_en_q     <= bp_en_d;
         first_q     <= first_d;
         widx_q      <= widx_d;
         shift_q     <= shift_d;
         csum_q      <= csum_d;
         tx_q        <= tx_d;
         start_q     <= start_d;
         hold_q      <= hold_d;
         csum_sent_q <= csum_sent_d;
         we_q        <= we_d;
         err_q       <= err_d;
         crst_q      <= crst_d;
      end
   end

   assign o_tx_data   = tx_q;
   assign o_tx_start  = start_q & ~i_reset;
   assign o_imem_addr = addr_q;
   assign o_imem_data = word_q;
   assign o_imem_we   = we_q & ~i_reset;
   assign o_cpu_en    = cpu_en & ~i_reset;
   assign o_cpu_reset = crst_q & ~i_reset;
   assign o_error     = err_q & ~i_reset;
   assign o_state     = state_q;
   assign o_reg_addr  = in_regs ? REG_AW'(widx_q - WIDX_W'(2)) : '0;
   assign o_mem_addr  = in_mem ? MEM_AW'(widx_q - WIDX_W'(2 + NREGS)) : '0;

endmodule

// File: tb/tb_debug_unit_v2.sv
// Directed bench for debug_unit_v2 with small core, register-file and UART models.
`timescale 1ns/1ps
module tb_debug_unit_v2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        halt;
   logic [31:0] pc = '0;
   logic [31:0] cyc = '0;
   logic [31:0] reg_rd = '0;
   logic [31:0] mem_rd = '0;
   logic [1:0]  reg_addr;
   logic [0:0]  mem_addr;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        imem_we;
   logic        cpu_en;
   logic        cpu_reset;
   logic        err;
   logic [3:0]  state;

   always #5 clk = ~clk;

   debug_unit_v2 #(
      .WORD_BYTES (4),
      .NREGS      (4),
      .NMEM       (2),
      .IMEM_DEPTH (256)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .i_tx_busy     (tx_busy),
      .o_tx_data     (tx_data),
      .o_tx_start    (tx_start),
      .i_halt        (halt),
      .i_pc          (pc),
      .i_cycle_count (cyc),
      .i_reg_data    (reg_rd),
      .i_mem_data    (mem_rd),
      .o_reg_addr    (reg_addr),
      .o_mem_addr    (mem_addr),
      .o_imem_addr   (imem_addr),
      .o_imem_data   (imem_data),
      .o_imem_we     (imem_we),
      .o_cpu_en      (cpu_en),
      .o_cpu_reset   (cpu_reset),
      .o_error       (err),
      .o_state       (state)
   );

   logic [31:0] regs [4] = '{32'h01020304, 32'hA5A5A5A5, 32'h0000FFFF, 32'h80000001};
   logic [31:0] mems [2] = '{32'hDEADBEEF, 32'h12345678};

   int   en_cnt = 0;
   int   halt_at = 1000000;
   int   busy_cnt = 0;
   int   crst_cnt = 0;
   int   err_cnt = 0;
   int   viol = 0;
   logic force_busy = 1'b0;
   logic [7:0]  txq [$];
   logic [7:0]  wr_addr [$];
   logic [31:0] wr_data [$];

   int checks = 0;
   int errors = 0;

   assign halt    = (en_cnt >= halt_at);
   assign tx_busy = force_busy || (busy_cnt != 0);

   always @(posedge clk) begin
      reg_rd <= regs[reg_addr];
      mem_rd <= mems[mem_addr];
      if (cpu_reset) begin
         pc  <= '0;
         cyc <= '0;
      end else if (cpu_en) begin
         pc     <= pc + 32'd4;
         cyc    <= cyc + 32'd1;
         en_cnt <= en_cnt + 1;
      end
      if (tx_start) begin
         txq.push_back(tx_data);
         busy_cnt <= 3;
         if (tx_busy) viol <= viol + 1;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_data);
      end
      if (cpu_reset) crst_cnt <= crst_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int t = 0;
      while (txq.size() < n && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(txq.size() >= n), 32'd1);
   endtask

   task automatic check_dump(input int base, input logic [31:0] epc, input logic [31:0] ecyc,
                             input string tag);
      logic [31:0] exp_w [8];
      logic [7:0]  cs;
      logic [31:0] got;
      exp_w[0] = epc;
      exp_w[1] = ecyc;
      for (int i = 0; i < 4; i++) exp_w[2+i] = regs[i];
      for (int i = 0; i < 2; i++) exp_w[6+i] = mems[i];
      cs = 8'h00;
      for (int w = 0; w < 8; w++) begin
         got = {txq[base+4*w], txq[base+4*w+1], txq[base+4*w+2], txq[base+4*w+3]};
         chk($sformatf("%s_w%0d", tag, w), got, exp_w[w]);
         for (int k = 0; k < 4; k++) cs = cs ^ exp_w[w][31-8*k -: 8];
      end
      chk($sformatf("%s_csum", tag), 32'(txq[base+32]), 32'(cs));
   endtask

   initial begin
      int base;
      int e0;
      int n0;
      logic [7:0] b;

      tick(3);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      rst = 1'b0;

      // Two-word program ending in the halt word
      send(8'h6C);
      send(8'h20); send(8'h01); send(8'h00); send(8'h05);
      repeat (4) send(8'hFF);
      tick(4);
      chk("load_nwr", 32'(wr_addr.size()), 32'd2);
      chk("load_a0", 32'(wr_addr[0]), 32'd0);
      chk("load_d0", wr_data[0], 32'h20010005);
      chk("load_a1", 32'(wr_addr[1]), 32'd4);
      chk("load_d1", wr_data[1], 32'hFFFFFFFF);
      chk("load_addr_end", 32'(imem_addr), 32'd0);
      chk("load_state_end", 32'(state), 32'd0);

      // 65 words overflow the 256-byte memory once, then the halt word
      n0 = wr_addr.size();
      e0 = err_cnt;
      send(8'h6C);
      for (int w = 0; w < 65; w++) begin
         b = 8'(w);
         send(8'h00); send(8'h00); send(8'h00); send(b);
      end
      repeat (4) send(8'hFF);
      tick(4);
      chk("wrap_nwr", 32'(wr_addr.size()), 32'(n0 + 66));
      chk("wrap_last_a", 32'(wr_addr[n0+63]), 32'd252);
      chk("wrap_a0", 32'(wr_addr[n0+64]), 32'd0);
      chk("wrap_d0", wr_data[n0+64], 32'h00000040);
      chk("wrap_halt_a", 32'(wr_addr[n0+65]), 32'd4);
      chk("wrap_err", 32'(err_cnt), 32'(e0 + 1));

      // Run to halt after 10 enabled cycles
      base = txq.size();
      e0 = en_cnt;
      halt_at = en_cnt + 10;
      send(8'h63);
      wait_tx(base + 33, "run_tmo");
      tick(6);
      chk("run_en", 32'(en_cnt - e0), 32'd10);
      check_dump(base, 32'd40, 32'd10, "run");
      chk("run_state_end", 32'(state), 32'd0);

      // Core reset command
      e0 = crst_cnt;
      send(8'h72);
      tick(2);
      chk("crst_pulse", 32'(crst_cnt), 32'(e0 + 1));
      chk("crst_pc", pc, 32'd0);

      // Breakpoint at 8, then resume through it
      send(8'h62);
      send(8'h00); send(8'h00); send(8'h00); send(8'h08);
      halt_at = en_cnt + 100;
      base = txq.size();
      e0 = en_cnt;
      send(8'h63);
      wait_tx(base + 33, "bp_tmo");
      tick(6);
      chk("bp_en", 32'(en_cnt - e0), 32'd2);
      check_dump(base, 32'd8, 32'd2, "bp");
      halt_at = en_cnt + 5;
      base = txq.size();
      e0 = en_cnt;
      send(8'h63);
      wait_tx(base + 33, "resume_tmo");
      tick(6);
      chk("resume_en", 32'(en_cnt - e0), 32'd5);
      check_dump(base, 32'd28, 32'd7, "resume");

      // Single step
      halt_at = en_cnt + 1000;
      send(8'h73);
      tick(2);
      chk("step_state", 32'(state), 32'd4);
      base = txq.size();
      e0 = en_cnt;
      send(8'h6E);
      wait_tx(base + 33, "step_tmo");
      tick(6);
      chk("step_en", 32'(en_cnt - e0), 32'd1);
      check_dump(base, 32'd32, 32'd8, "step");
      chk("step_state_back", 32'(state), 32'd4);
      send(8'h71);
      tick(2);
      chk("quit_state", 32'(state), 32'd0);

      // Unknown command
      e0 = err_cnt;
      send(8'h7A);
      tick(2);
      chk("bad_cmd_err", 32'(err_cnt), 32'(e0 + 1));
      chk("bad_cmd_state", 32'(state), 32'd0);

      // Transmitter held busy
      force_busy = 1'b1;
      base = txq.size();
      send(8'h64);
      tick(100);
      chk("busy_hold", 32'(txq.size()), 32'(base));
      force_busy = 1'b0;
      wait_tx(base + 33, "busy_tmo");
      tick(6);
      check_dump(base, 32'd32, 32'd8, "busy");

      // Reset in the middle of a dump
      base = txq.size();
      send(8'h64);
      wait_tx(base + 5, "mid_tmo");
      @(negedge clk);
      rst = 1'b1;
      n0 = txq.size();
      tick(1);
      chk("mid_state", 32'(state), 32'd0);
      chk("mid_tx_data", 32'(tx_data), 32'd0);
      chk("mid_tx_start", 32'(tx_start), 32'd0);
      chk("mid_reg_addr", 32'(reg_addr), 32'd0);
      chk("mid_mem_addr", 32'(mem_addr), 32'd0);
      chk("mid_cpu_en", 32'(cpu_en), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(100);
      chk("mid_no_start", 32'(txq.size()), 32'(n0));
      chk("mid_idle", 32'(state), 32'd0);

      chk("busy_violation", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_unit_v2.md
Name: debug_unit_v2

Overview:
UART-driven debug controller for the MIPS core, parametrised in word width, register and data-memory dump depth, and instruction-memory depth. It loads programs into instruction memory and runs the core in continuous or single-step mode. New over the previous controller: a hardware PC breakpoint, a manual break, a core-reset command, an XOR-checksummed dump, and a clean valid/busy UART handshake. It sits between the UART rx/tx pair and the core's clock-enable, instruction-memory write port and debug read ports.

Parameters:
WORD_BYTES, 4, bytes per core word; NBITS = 8*WORD_BYTES
NREGS, 32, registers dumped; REG_AW = clog2(NREGS)
NMEM, 16, data-memory words dumped; MEM_AW = clog2(NMEM)
IMEM_DEPTH, 256, instruction-memory size in bytes; IMEM_AW = clog2(IMEM_DEPTH)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle pulse; i_rx_data valid
i_tx_busy  in  1  UART transmitter busy
o_tx_data  out  8  byte to send
o_tx_start  out  1  one-cycle start pulse
i_halt  in  1  core executed halt
i_pc  in  NBITS  core PC
i_cycle_count  in  NBITS  core cycle counter
i_reg_data  in  NBITS  register file read data (1-cycle latency after o_reg_addr)
i_mem_data  in  NBITS  data memory read data (1-cycle latency after o_mem_addr)
o_reg_addr  out  REG_AW  register dump address
o_mem_addr  out  MEM_AW  data-memory dump address
o_imem_addr  out  IMEM_AW  instruction write byte address
o_imem_data  out  NBITS  instruction write data
o_imem_we  out  1  one-cycle write strobe
o_cpu_en  out  1  core clock enable
o_cpu_reset  out  1  one-cycle core reset pulse
o_error  out  1  one-cycle error pulse
o_state  out  4  current state code

Behaviour:
- Reset: all outputs 0. State IDLE (code 0). Breakpoint disabled; bp address 0; imem address 0. Reset mid-operation aborts immediately; no further o_tx_start or o_imem_we.
- IDLE (0) accepts commands on i_rx_valid:
  - 'l' 0x6C → LOAD.
  - 'c' 0x63 → RUN.
  - 's' 0x73 → STEP.
  - 'b' 0x62 → BRK.
  - 'd' 0x64 → DUMP, then back to IDLE.
  - 'r' 0x72 → o_cpu_reset high for 1 cycle; stays in IDLE.
  - 'k' 0x6B → clears the breakpoint enable.
  - Any other byte → o_error pulse; stays in IDLE.
- LOAD (1): shifts bytes in MSB first. After WORD_BYTES bytes, the next cycle drives o_imem_we=1 with the assembled word at o_imem_addr. After the write, the address advances by WORD_BYTES.
  - If the word is all-ones (halt): it is written, the address returns to 0 and the state goes to IDLE.
  - If the address would exceed IMEM_DEPTH-WORD_BYTES: it wraps to 0 with an o_error pulse, and loading continues.
- BRK (2): receives WORD_BYTES bytes MSB first into the bp address, sets bp enable, → IDLE.
- RUN (3): o_cpu_en = 1 except in a stop cycle. Stop conditions:
  - i_halt;
  - bp enabled and i_pc == bp address — ignored in the first RUN cycle so execution can resume from a breakpoint;
  - received 'x' 0x78 (manual break).
  - On any stop: o_cpu_en=0 in that cycle, → DUMP, then → IDLE.
- STEP (4): waits for a byte.
  - 'n' 0x6E: if i_halt, dump and → IDLE. Otherwise o_cpu_en=1 for exactly one cycle, dump, then return to STEP.
  - 'q' 0x71 → IDLE.
  - Other bytes are ignored.
- Rx bytes arriving in any state not listed as accepting them are dropped.
- DUMP sequence (codes 5 addr, 6 load, 7 send, 8 wait, 9 checksum):
  - Word order: i_pc, i_cycle_count, registers 0..NREGS-1, memory words 0..NMEM-1. Each word is sent MSB byte first. Then one checksum byte = XOR of all preceding bytes of this dump.
  - Total bytes = WORD_BYTES*(2+NREGS+NMEM)+1.
  - Read timing: address driven in the addr state; data captured in the next cycle.
- Tx handshake:
  - o_tx_start is issued only when i_tx_busy=0; o_tx_data is stable from start until the next start.
  - After a start, i_tx_busy is ignored for 1 cycle, then the controller waits for i_tx_busy=0 before the next start.
- o_reg_addr and o_mem_addr return to 0 at the end of the dump.

Test Plan:
- Bench params: WORD_BYTES=4, NREGS=4, NMEM=2.
- Load: 'l', 0x20,0x01,0x00,0x05, 0xFF×4 → writes 0x20010005@0, 0xFFFFFFFF@4 (one strobe each), then IDLE with o_imem_addr=0.
- Run to halt: 'c', halt after 10 cycles → o_cpu_en high 10 cycles; 33 bytes sent: PC, count, regs r0..r3, mem m0..m1, XOR checksum correct.
- Breakpoint: 'b',0,0,0,8 then 'c' with PC reaching 8 → o_cpu_en low that cycle, dump; second 'c' → runs past 8, no immediate stop.
- Step: 's','n' → exactly 1 o_cpu_en cycle, 33-byte dump, o_state=4; 'q' → IDLE.
- Robustness:
  - 'z' in IDLE → o_error pulse.
  - tx_busy held 100 cycles → next byte waits for it.
  - i_reset mid-dump → no further starts, all outputs 0.
